p2p_bus_arbiter: RTL and testbench
==================================

Name: p2p_bus_arbiter

Overview:
- Round-robin arbiter and transfer sequencer for a shared 4-bit message bus that replaces dedicated point-to-point links between nodes.
- N requesters each present a message and a destination ID. The arbiter grants one requester at a time, drives the shared bus and waits for the destination's ack.
- It then reports completion and rotates priority.
- Sits between the node modules and the shared bus wiring in the interconnect top level.

Parameters:
- N, 4, number of requesters (2..8)
- W, 4, message width in bits
- DW, 2, destination ID width; must be at least clog2(N)
- TIMEOUT, 8, cycles in XFER without bus_ack before abort (1..255)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  request per node; held high until that node's done pulse
- req_data  in  N*W  message of node i at bits [i*W +: W]
- req_dest  in  N*DW  destination of node i at bits [i*DW +: DW]
- gnt  out  N  one-hot grant, registered
- done  out  N  one-cycle completion pulse to the granted node
- bus_valid  out  1  shared bus carries a valid message
- bus_data  out  W  shared bus message
- bus_dest  out  DW  shared bus destination ID
- bus_ack  in  1  destination accepted message (sampled only in XFER)
- err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async assert, sync release). All outputs are 0, FSM=IDLE, rr_ptr=0, winner=0, tcnt=0. Reset mid-transfer drops bus_valid and gnt immediately and emits no done.
- FSM states: IDLE, GRANT, XFER.
- IDLE:
  - If req!=0, pick the winner as the first set req[i] scanning i = rr_ptr, rr_ptr+1, ... mod N.
  - Register gnt = onehot(winner) and go to GRANT.
  - If req==0, stay in IDLE with gnt=0.
- GRANT (exactly 1 cycle):
  - Latch bus_data = req_data[winner] and bus_dest = req_dest[winner].
  - Set bus_valid=1, tcnt=0, go to XFER.
  - gnt stays asserted.
- XFER:
  - bus_valid, bus_data and bus_dest stay constant. Requester inputs are ignored, including req dropping.
  - bus_ack=1 completes the transfer at this edge: done[winner]=1 for 1 cycle; gnt=0; bus_valid=0; bus_data and bus_dest hold their last value; rr_ptr = (winner+1) mod N; go to IDLE.
  - bus_ack=0 increments tcnt.
- Latency:
  - req rising before edge k gives gnt at edge k and bus_valid at edge k+1.
  - With ack sampled at edge k+2, done is high during the cycle after edge k+2.
  - Minimum 3 cycles per transfer. The next grant comes no earlier than 1 cycle after done (IDLE re-arbitrates).
- Requester obligation: a node still high on req in the cycle its done is asserted is treated as a new request. It is served only after rr rotation.
- bus_ack outside XFER is ignored.
- Simultaneous requests are resolved purely by rr_ptr. A continuously requesting node waits at most N-1 transfers.
- Invariant: gnt is zero or one-hot, and bus_valid=1 implies gnt!=0.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - In XFER, if bus_ack=0 and tcnt==TIMEOUT-1 at an edge, abort.
  - Abort drives err=1 for 1 cycle and done[winner]=1 in the same cycle.
  - gnt=0, bus_valid=0, rr_ptr=(winner+1) mod N, go to IDLE.
  - Ack at that same edge wins: normal completion, no err.
- ARB_TIMEOUT_EN undefined:
  - XFER waits indefinitely for bus_ack.
  - tcnt is not implemented and err is tied to 0.

Test Plan:
- Single request (N=4): req=0010, req_data[1]=1011, req_dest[1]=3, ack 1 cycle after bus_valid -> gnt=0010 at edge 1; bus_valid=1, bus_data=1011, bus_dest=3 at edge 2; done=0010 for 1 cycle; rr_ptr=2.
- Round-robin fairness: req=1111 held, each node drops req on its done, immediate ack -> grant order 0,1,2,3. Re-assert all -> order continues from rr_ptr=0. No node is granted twice before the others.
- Priority rotation: after serving node 2, assert req=0101 simultaneously -> node 0 granted first (scan 3,0,...), then node 2.
- Late ack and input change: hold bus_ack=0 for 5 cycles and change req_data[winner] during XFER -> bus_data unchanged; done only after ack; err stays 0 (TIMEOUT=8).
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): never ack -> err and done[winner] pulse together 8 cycles after bus_valid rises, bus_valid=0, next requester granted. Without the macro -> bus_valid stays 1 for 50 cycles and err=0.
- Async reset: assert rst_n=0 mid-XFER between clock edges -> gnt, bus_valid, done and err go to 0 immediately. After release with req=1000 -> node 3 granted and rr_ptr starts from 0.

Source files
------------

// File: rtl/p2p_bus_arbiter_if.sv
// Shared message-bus bundle between the requesting nodes and p2p_bus_arbiter.
// master = arbiter side, slave = node/bus-wiring side.
interface p2p_bus_arbiter_if #(
   parameter int N  = 4,
   parameter int W  = 4,
   parameter int DW = 2
) ();
   logic [N-1:0]    req;
   logic [N*W-1:0]  req_data;
   logic [N*DW-1:0] req_dest;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic            bus_valid;
   logic [W-1:0]    bus_data;
   logic [DW-1:0]   bus_dest;
   logic            bus_ack;
   logic            err;

   modport master (
      input  req, req_data, req_dest, bus_ack,
      output gnt, done, bus_valid, bus_data, bus_dest, err
   );

   modport slave (
      output req, req_data, req_dest, bus_ack,
      input  gnt, done, bus_valid, bus_data, bus_dest, err
   );
endinterface

// File: rtl/p2p_bus_arbiter.sv
// Round-robin arbiter and transfer sequencer for a shared message bus (IDLE/GRANT/XFER).
// Define ARB_TIMEOUT_EN to abort an unacknowledged transfer after TIMEOUT cycles.
module p2p_bus_arbiter #(
   parameter int N       = 4,
   parameter int W       = 4,
   parameter int DW      = 2,
   parameter int TIMEOUT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   p2p_bus_arbiter_if.master  bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (N < 2 || N > 8 || DW < $clog2(N) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("p2p_bus_arbiter: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, GRANT, XFER} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   winner_q, winner_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [N-1:0]    done_q, done_d;
   logic            bus_valid_q, bus_valid_d;
   logic [W-1:0]    bus_data_q, bus_data_d;
   logic [DW-1:0]   bus_dest_q, bus_dest_d;

   logic            found;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   winner_nxt;
   logic            abort;
   int              idx;

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   // First set request scanning upward from rr_ptr, wrapping at N.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(rr_ptr_q) + i) % N;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   assign winner_nxt = (winner_q == IW'(N - 1)) ? '0 : winner_q + IW'(1);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      winner_d    = winner_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      bus_valid_d = bus_valid_q;
      bus_data_d  = bus_data_q;
      bus_dest_d  = bus_dest_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               winner_d = pick;
               gnt_d    = onehot(pick);
               state_d  = GRANT;
            end
         end
         GRANT: begin
            bus_data_d  = bus.req_data[int'(winner_q)*W +: W];
            bus_dest_d  = bus.req_dest[int'(winner_q)*DW +: DW];
            bus_valid_d = 1'b1;
            state_d     = XFER;
         end
         XFER: begin
            // Requester inputs are ignored here; only ack (or abort) ends the transfer.
            if (bus.bus_ack || abort) begin
               done_d      = onehot(winner_q);
               gnt_d       = '0;
               bus_valid_d = 1'b0;
               rr_ptr_d    = winner_nxt;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         winner_q    <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         bus_valid_q <= 1'b0;
         bus_data_q  <= '0;
         bus_dest_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         winner_q    <= winner_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         bus_valid_q <= bus_valid_d;
         bus_data_q  <= bus_data_d;
         bus_dest_q  <= bus_dest_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] tcnt_q, tcnt_d;
   logic       err_q, err_d;

   // An ack on the final cycle wins over the abort.
   assign abort = (state_q == XFER) && !bus.bus_ack && (tcnt_q == 8'(TIMEOUT - 1));

   always_comb begin
      tcnt_d = tcnt_q;
      if (state_q == GRANT)
         tcnt_d = '0;
      else if (state_q == XFER && !bus.bus_ack)
         tcnt_d = tcnt_q + 8'd1;
      err_d = abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         err_q  <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign abort   = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.bus_valid = bus_valid_q;
   assign bus.bus_data  = bus_data_q;
   assign bus.bus_dest  = bus_dest_q;

endmodule

// File: tb/tb_p2p_bus_arbiter.sv
// Scoreboard bench for p2p_bus_arbiter: expected messages queued at request time,
// popped when bus_valid rises; grant order checked against a round-robin model.
module tb_p2p_bus_arbiter;
   localparam int N       = 4;
   localparam int W       = 4;
   localparam int DW      = 2;
   localparam int TIMEOUT = 8;

   typedef struct {
      int            node;
      logic [W-1:0]  data;
      logic [DW-1:0] dest;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total    = 0;
   int   bad      = 0;
   int   inv_bad  = 0;
   int   model_rr = 0;
   exp_t sbq[$];

   p2p_bus_arbiter_if #(.N(N), .W(W), .DW(DW)) ifc ();

   p2p_bus_arbiter #(.N(N), .W(W), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (!$onehot0(ifc.gnt) || (ifc.bus_valid && ifc.gnt == '0))
            inv_bad <= inv_bad + 1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] onehot_v(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0 && i < N) v[i] = 1'b1;
      return v;
   endfunction

   function automatic int gnt_idx(input logic [N-1:0] g);
      for (int i = 0; i < N; i++)
         if (g == onehot_v(i)) return i;
      return -1;
   endfunction

   function automatic int model_pick();
      int j;
      for (int i = 0; i < N; i++) begin
         j = (model_rr + i) % N;
         if (ifc.req[j]) return j;
      end
      return -1;
   endfunction

   // Called at a negedge with req already driven and the arbiter idle.
   task automatic start_xfer(output int w);
      exp_t e;
      int   t;
      int   exp_w;
      exp_w = model_pick();
      if (exp_w >= 0) begin
         e.node = exp_w;
         e.data = ifc.req_data[exp_w*W +: W];
         e.dest = ifc.req_dest[exp_w*DW +: DW];
         sbq.push_back(e);
      end
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (ifc.gnt == '0 && t < 8);
      chk("grant_latency", t, 1);
      chk("gnt", ifc.gnt, onehot_v(exp_w));
      chk("done_pulse_end", ifc.done, '0);
      w = gnt_idx(ifc.gnt);
      if (w < 0) w = (exp_w < 0) ? 0 : exp_w;
      @(negedge clk);
      chk("bus_valid_rise", ifc.bus_valid, 1);
      chk("sb_depth", sbq.size(), 1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("bus_data", ifc.bus_data, e.data);
         chk("bus_dest", ifc.bus_dest, e.dest);
         chk("gnt_hold", ifc.gnt, onehot_v(e.node));
      end
   endtask

   task automatic finish_xfer(input int w, input int ack_wait, input bit wiggle);
      logic [W-1:0] held;
      int           hold_bad;
      held     = ifc.bus_data;
      hold_bad = 0;
      if (wiggle) begin
         ifc.req_data[w*W +: W] = ~ifc.req_data[w*W +: W];
         ifc.req_dest[w*DW +: DW] = ~ifc.req_dest[w*DW +: DW];
      end
      for (int c = 0; c < ack_wait; c++) begin
         @(negedge clk);
         if (ifc.bus_valid !== 1'b1 || ifc.bus_data !== held || ifc.done !== '0 || ifc.err !== 1'b0)
            hold_bad++;
      end
      chk("xfer_hold", hold_bad, 0);
      ifc.bus_ack = 1'b1;
      @(negedge clk);
      ifc.bus_ack = 1'b0;
      chk("done", ifc.done, onehot_v(w));
      chk("done_valid_low", ifc.bus_valid, 0);
      chk("done_gnt_low", ifc.gnt, '0);
      chk("done_err", ifc.err, 0);
      chk("data_hold_after", ifc.bus_data, held);
      ifc.req[w] = 1'b0;
      model_rr   = (w + 1) % N;
   endtask

   task automatic serve(input int ack_wait, input bit wiggle, output int w);
      start_xfer(w);
      finish_xfer(w, ack_wait, wiggle);
   endtask

   task automatic rand_payload();
      for (int i = 0; i < N; i++) begin
         ifc.req_data[i*W +: W]   = W'($urandom_range(0, 15));
         ifc.req_dest[i*DW +: DW] = DW'($urandom_range(0, 3));
      end
   endtask

   initial begin
      int           w;
      int           start;
      int           cnt;
      logic [N-1:0] seen;

      rst_n       = 1'b0;
      ifc.req     = '0;
      ifc.req_data = '0;
      ifc.req_dest = '0;
      ifc.bus_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", ifc.gnt, '0);
      chk("rst_done", ifc.done, '0);
      chk("rst_valid", ifc.bus_valid, 0);
      chk("rst_data", ifc.bus_data, '0);
      chk("rst_dest", ifc.bus_dest, '0);
      chk("rst_err", ifc.err, 0);
      rst_n = 1'b1;

      // Stray ack while idle
      ifc.bus_ack = 1'b1;
      @(negedge clk);
      ifc.bus_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_gnt", ifc.gnt, '0);
      chk("idle_ack_done", ifc.done, '0);

      // Single request from node 1
      ifc.req_data[1*W +: W]   = 4'b1011;
      ifc.req_dest[1*DW +: DW] = 2'd3;
      ifc.req = 4'b0010;
      start_xfer(w);
      chk("single_node", w, 1);
      chk("single_data", ifc.bus_data, 4'b1011);
      chk("single_dest", ifc.bus_dest, 2'd3);
      finish_xfer(w, 0, 1'b0);

      // Priority rotation: after node 2, {0,2} -> 0 first
      rand_payload();
      ifc.req = 4'b0100;
      serve(0, 1'b0, w);
      chk("rot_setup", w, 2);
      ifc.req = 4'b0101;
      serve(0, 1'b0, w);
      chk("rot_first", w, 0);
      serve(0, 1'b0, w);
      chk("rot_second", w, 2);

      // Fairness: all request, two rounds
      for (int r = 0; r < 2; r++) begin
         rand_payload();
         ifc.req = '1;
         start   = model_rr;
         seen    = '0;
         for (int k = 0; k < N; k++) begin
            serve(0, 1'b0, w);
            chk("fair_order", w, (start + k) % N);
            seen |= onehot_v(w);
         end
         chk("fair_all_served", seen, {N{1'b1}});
      end

      // Late ack with payload change during the transfer
      rand_payload();
      ifc.req = 4'b0001;
      serve(5, 1'b1, w);
      chk("late_node", w, 0);

`ifdef ARB_TIMEOUT_EN
      rand_payload();
      ifc.req = 4'b0110;
      start_xfer(w);
      cnt = 0;
      while (ifc.err !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("tmo_cycles", cnt, TIMEOUT);
      chk("tmo_done", ifc.done, onehot_v(w));
      chk("tmo_valid", ifc.bus_valid, 0);
      ifc.req[w] = 1'b0;
      model_rr   = (w + 1) % N;
      serve(0, 1'b0, w);
      chk("tmo_next_node", w, 2);
`else
      rand_payload();
      ifc.req = 4'b0100;
      start_xfer(w);
      cnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (ifc.bus_valid !== 1'b1 || ifc.err !== 1'b0 || ifc.done !== '0) cnt++;
      end
      chk("no_tmo_hold", cnt, 0);
      finish_xfer(w, 0, 1'b0);
`endif

      // Async reset in the middle of a transfer
      rand_payload();
      ifc.req = 4'b0010;
      serve(0, 1'b0, w);
      ifc.req = 4'b0100;
      start_xfer(w);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gnt", ifc.gnt, '0);
      chk("arst_valid", ifc.bus_valid, 0);
      chk("arst_done", ifc.done, '0);
      chk("arst_err", ifc.err, 0);
      ifc.req = '0;
      @(negedge clk);
      @(negedge clk);
      chk("arst_no_done", ifc.done, '0);
      rst_n    = 1'b1;
      model_rr = 0;
      sbq.delete();
      ifc.req = 4'b1010;
      serve(0, 1'b0, w);
      chk("arst_rr_zero", w, 1);
      serve(0, 1'b0, w);
      chk("arst_node3", w, 3);

      chk("invariant", inv_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
